multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the MIPS-subset CPU datapath. It replaces single-cycle decoding with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux, write-enable and ALU-op control. It waits on a variable-latency unified memory through a ready handshake, and keeps a retired-instruction count.

## Interface
Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `op_i`  in  6  opcode field of the instruction register.
- `funct_i`  in  6  funct field of the instruction register.
- `mem_ready_i`  in  1  memory has completed the current read or write this cycle.
- `pc_write_o`  out  1  PC unconditional write enable.
- `pc_write_cond_o`  out  1  PC write, qualified by the datapath's selected zero flag.
- `pc_source_o`  out  2  PC source: 00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target.
- `iord_o`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `mem_read_o`  out  1  memory read request.
- `mem_write_o`  out  1  memory write request.
- `ir_write_o`  out  1  instruction register load.
- `reg_write_o`  out  1  register file write.
- `reg_dst_o`  out  1  destination register: 1 = rd, 0 = rt.
- `mem_to_reg_o`  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- `alu_src_a_o`  out  2  ALU A input: 00 PC, 01 rs, 10 shamt (zero-extended).
- `alu_src_b_o`  out  2  ALU B input: 00 rt, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left by 2.
- `alu_op_o`  out  3  ALU op: 000 add, 010 funct-controlled, 110 subtract/compare, 111 sltiu, 001 or, 100 lui.
- `imm_ext_sel_o`  out  1  1 = zero-extend the immediate, 0 = sign-extend.
- `zero_sel_o`  out  1  1 = the branch condition is the inverted zero flag (bne).
- `illegal_o`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_count_o`  out  CNT_W  number of retired instructions.

## Operation
Supported opcodes:
- R-type 000000; within it, sra is funct 3 and srav is funct 7.
- addi 001000, sltiu 001001, ori 001101, lui 001111.
- beq 000100, bne 000101, j 000010.
- lw 100011, sw 101011.

States and transitions:
- FETCH: drives `mem_read_o`=1, `iord_o`=0, `alu_src_a_o`=00, `alu_src_b_o`=01, `alu_op_o`=000.
  - Stays in FETCH while `mem_ready_i`=0.
  - In the cycle `mem_ready_i`=1, pulses `ir_write_o` and `pc_write_o` (with `pc_source_o`=00), then goes to DECODE.
- DECODE: computes the branch target (`alu_src_a_o`=00, `alu_src_b_o`=11, `alu_op_o`=000). It samples `op_i`/`funct_i` into an internal class register and branches on the class:
  - R-type other than sra/srav → EXEC_R.
  - sra/srav → EXEC_SH.
  - addi/sltiu/ori/lui → EXEC_I.
  - lw/sw → MEM_ADDR.
  - beq/bne → BRANCH.
  - j → JUMP.
  - Any other opcode → FETCH, with `illegal_o` pulsed.
- EXEC_R: `alu_src_a_o`=01, `alu_src_b_o`=00, `alu_op_o`=010; next state WB_R.
- EXEC_SH: `alu_op_o`=010, `alu_src_b_o`=00. `alu_src_a_o`=10 for sra and 01 for srav. Next state WB_R.
- EXEC_I: `alu_src_a_o`=01, `alu_src_b_o`=10.
  - `alu_op_o` is 000 for addi, 111 for sltiu, 001 for ori, 100 for lui.
  - `imm_ext_sel_o`=1 for sltiu and ori.
  - Next state WB_I.
- WB_R / WB_I: `reg_write_o`=1, `mem_to_reg_o`=0, `reg_dst_o`=1 in WB_R and 0 in WB_I. Next state FETCH; the instruction retires.
- MEM_ADDR: `alu_src_a_o`=01, `alu_src_b_o`=10, `alu_op_o`=000; next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read_o`=1, `iord_o`=1; stays until `mem_ready_i`=1, then goes to WB_MEM.
- MEM_WR: `mem_write_o`=1, `iord_o`=1; stays until `mem_ready_i`=1, then goes to FETCH and the instruction retires.
- WB_MEM: `reg_write_o`=1, `mem_to_reg_o`=1, `reg_dst_o`=0; next state FETCH and the instruction retires.
- BRANCH: `alu_src_a_o`=01, `alu_src_b_o`=00, `alu_op_o`=110, `pc_write_cond_o`=1, `pc_source_o`=01, `zero_sel_o`=1 for bne. Next state FETCH and the instruction retires.
- JUMP: `pc_write_o`=1, `pc_source_o`=10; next state FETCH and the instruction retires.

Output and counter rules:
- Every output not listed for a state is 0.
- `instr_count_o` increments by 1 in the cycle of each retiring transition and wraps modulo 2^CNT_W. Illegal opcodes do not retire.

## Timing
- Reset: while `rst_i`=1, state is FETCH, the class register and `instr_count_o` are 0, and all outputs are forced to 0, including `mem_read_o`.
  - After `rst_i` deasserts, FETCH drives its outputs in the next cycle.
  - Reset asserted mid-instruction aborts the instruction with no write enable left asserted.
- Outputs are registered-state Moore decodes. The only exceptions are `ir_write_o` and `pc_write_o` in FETCH, which are gated by `mem_ready_i`.
- Cycle counts with zero wait states:
  - branch/jump: 3
  - R/I/shift: 4
  - sw: 4
  - lw: 5
- Each wait cycle (`mem_ready_i`=0) adds exactly one cycle.
- `mem_read_o` and `mem_write_o` are held stable until ready; they are never both asserted.
- `mem_ready_i` outside FETCH, MEM_RD and MEM_WR is ignored.
- `op_i` and `funct_i` are used only in DECODE; changes in other states have no effect.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - opcode and funct constants;
  - ALU-op codes;
  - `pc_source`/`alu_src` encodings;
  - the state enum.
- Sub-module `mc_op_classify`: a combinational block that maps `op_i`/`funct_i` to a one-hot class (R, SH_IMM, SH_VAR, ADDI, SLTIU, ORI, LUI, LW, SW, BEQ, BNE, J, ILLEGAL). The FSM registers this class in DECODE.

## Test plan
- Reset then add (op 0, funct 32), `mem_ready_i` held 1 → state sequence FETCH, DECODE, EXEC_R, WB_R; `reg_write_o`=1 and `reg_dst_o`=1 in cycle 4; `instr_count_o`=1.
- lw with 2 wait cycles in FETCH and 1 in MEM_RD → 8 total cycles; `ir_write_o` pulses exactly once; `mem_to_reg_o`=1 in WB_MEM.
- bne then beq → `pc_write_cond_o`=1 with `alu_op_o`=110 in cycle 3 for both; `zero_sel_o`=1 only for bne.
- sra (funct 3), then srav (funct 7), then ori → `alu_src_a_o`=10, then 01; ori gives `alu_op_o`=001 with `imm_ext_sel_o`=1.
- Opcode 111111 → `illegal_o` pulses in cycle 2, return to FETCH, `instr_count_o` unchanged.
- `rst_i` asserted during MEM_WR → `mem_write_o` drops to 0 immediately (asynchronous); restart in FETCH with `instr_count_o`=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control sequencer:
// opcodes, funct codes, ALU ops, datapath mux selects, FSM states and the one-hot class.
package mc_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [OP_W-1:0] FUNCT_SRA  = 6'd3;
  localparam logic [OP_W-1:0] FUNCT_SRAV = 6'd7;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_LUI   = 3'b100;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b110;
  localparam logic [ALUOP_W-1:0] ALU_SLTIU = 3'b111;

  localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [SEL_W-1:0] ALU_A_PC    = 2'b00;
  localparam logic [SEL_W-1:0] ALU_A_RS    = 2'b01;
  localparam logic [SEL_W-1:0] ALU_A_SHAMT = 2'b10;

  localparam logic [SEL_W-1:0] ALU_B_RT     = 2'b00;
  localparam logic [SEL_W-1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [SEL_W-1:0] ALU_B_IMM    = 2'b10;
  localparam logic [SEL_W-1:0] ALU_B_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_SH  = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  // One-hot instruction class; exactly one field is set for any op/funct.
  typedef struct packed {
    logic r;
    logic sh_imm;
    logic sh_var;
    logic addi;
    logic sltiu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/mc_op_classify.sv
// Combinational opcode/funct classifier producing the one-hot instruction class.
module mc_op_classify
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  output op_class_t       cls
);

  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_SRA)       cls.sh_imm = 1'b1;
        else if (funct == FUNCT_SRAV) cls.sh_var = 1'b1;
        else                          cls.r      = 1'b1;
      end
      OP_ADDI:  cls.addi    = 1'b1;
      OP_SLTIU: cls.sltiu   = 1'b1;
      OP_ORI:   cls.ori     = 1'b1;
      OP_LUI:   cls.lui     = 1'b1;
      OP_LW:    cls.lw      = 1'b1;
      OP_SW:    cls.sw      = 1'b1;
      OP_BEQ:   cls.beq     = 1'b1;
      OP_BNE:   cls.bne     = 1'b1;
      OP_J:     cls.j       = 1'b1;
      default:  cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS-subset datapath with memory
// ready handshake and a retired-instruction counter.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [OP_W-1:0]      op_i,
  input  logic [OP_W-1:0]      funct_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 pc_write_cond_o,
  output logic [SEL_W-1:0]     pc_source_o,
  output logic                 iord_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 ir_write_o,
  output logic                 reg_write_o,
  output logic                 reg_dst_o,
  output logic                 mem_to_reg_o,
  output logic [SEL_W-1:0]     alu_src_a_o,
  output logic [SEL_W-1:0]     alu_src_b_o,
  output logic [ALUOP_W-1:0]   alu_op_o,
  output logic                 imm_ext_sel_o,
  output logic                 zero_sel_o,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     instr_count_o
);

  state_t    state_q, state_d;
  op_class_t cls_c, cls_q;
  logic      run_q;
  logic      retire_c;

  mc_op_classify u_classify (
    .op    (op_i),
    .funct (funct_i),
    .cls   (cls_c)
  );

  // run_q keeps every output low for the first cycle after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      cls_q         <= '0;
      run_q         <= 1'b0;
      instr_count_o <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_c;
      if (retire_c) instr_count_o <= instr_count_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_d         = state_q;
    retire_c        = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = PC_SRC_ALU;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    alu_src_a_o     = ALU_A_PC;
    alu_src_b_o     = ALU_B_RT;
    alu_op_o        = ALU_ADD;
    imm_ext_sel_o   = 1'b0;
    zero_sel_o      = 1'b0;
    illegal_o       = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = ALU_B_FOUR;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b_o = ALU_B_IMM_SH;
          if (cls_c.r)                                       state_d = S_EXEC_R;
          else if (cls_c.sh_imm || cls_c.sh_var)             state_d = S_EXEC_SH;
          else if (cls_c.addi || cls_c.sltiu || cls_c.ori || cls_c.lui)
                                                             state_d = S_EXEC_I;
          else if (cls_c.lw || cls_c.sw)                     state_d = S_MEM_ADDR;
          else if (cls_c.beq || cls_c.bne)                   state_d = S_BRANCH;
          else if (cls_c.j)                                  state_d = S_JUMP;
          else begin
            illegal_o = 1'b1;
            state_d   = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_src_a_o = ALU_A_RS;
          alu_op_o    = ALU_FUNCT;
          state_d     = S_WB_R;
        end
        S_EXEC_SH: begin
          alu_src_a_o = cls_q.sh_imm ? ALU_A_SHAMT : ALU_A_RS;
          alu_op_o    = ALU_FUNCT;
          state_d     = S_WB_R;
        end
        S_EXEC_I: begin
          alu_src_a_o   = ALU_A_RS;
          alu_src_b_o   = ALU_B_IMM;
          imm_ext_sel_o = cls_q.sltiu | cls_q.ori;
          if (cls_q.sltiu)    alu_op_o = ALU_SLTIU;
          else if (cls_q.ori) alu_op_o = ALU_OR;
          else if (cls_q.lui) alu_op_o = ALU_LUI;
          state_d = S_WB_I;
        end
        S_WB_R, S_WB_I: begin
          reg_write_o = 1'b1;
          reg_dst_o   = (state_q == S_WB_R);
          retire_c    = 1'b1;
          state_d     = S_FETCH;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = ALU_A_RS;
          alu_src_b_o = ALU_B_IMM;
          if (cls_q.lw)      state_d = S_MEM_RD;
          else if (cls_q.sw) state_d = S_MEM_WR;
          else               state_d = S_FETCH;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
          if (mem_ready_i) state_d = S_WB_MEM;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
          if (mem_ready_i) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
        end
        S_WB_MEM: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          retire_c     = 1'b1;
          state_d      = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a_o     = ALU_A_RS;
          alu_op_o        = ALU_SUB;
          pc_write_cond_o = 1'b1;
          pc_source_o     = PC_SRC_ALUOUT;
          zero_sel_o      = cls_q.bne;
          retire_c        = 1'b1;
          state_d         = S_FETCH;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = PC_SRC_JUMP;
          retire_c    = 1'b1;
          state_d     = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Class bits that only steer DECODE and are not needed once registered.
  logic unused_cls;
  assign unused_cls = ^{cls_q.r, cls_q.sh_var, cls_q.addi, cls_q.beq, cls_q.j, cls_q.illegal};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  op = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        ready = 1'b1;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg, imm_ext_sel, zero_sel, illegal;
  logic [1:0]  pc_source, alu_src_a, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct_i(funct), .mem_ready_i(ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_source_o(pc_source),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .imm_ext_sel_o(imm_ext_sel), .zero_sel_o(zero_sel), .illegal_o(illegal),
    .instr_count_o(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    tick(); tick();
    checks++;
    if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {mem_read, ir_write, pc_write, alu_src_b});
    end
    checks++;
    if (count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    rst = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL release_cycle_quiet: mem_read %b expected 0", mem_read); end
    tick();
    checks++;
    if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin
      errors++; $display("FAIL fetch_after_reset: got %b expected 11101", {mem_read, ir_write, pc_write, alu_src_b});
    end
  endtask

  task automatic test_add();
    op = 6'd0; funct = 6'd32; ready = 1'b1;
    tick();
    checks++;
    if ({alu_src_b, mem_read, illegal} !== 4'b1100) begin
      errors++; $display("FAIL add_decode: got %b expected 1100", {alu_src_b, mem_read, illegal});
    end
    tick();
    checks++;
    if ({alu_src_a, alu_src_b, alu_op} !== 7'b0100010) begin
      errors++; $display("FAIL add_exec: got %b expected 0100010", {alu_src_a, alu_src_b, alu_op});
    end
    tick();
    checks++;
    if ({reg_write, reg_dst, mem_to_reg} !== 3'b110) begin
      errors++; $display("FAIL add_wb: got %b expected 110", {reg_write, reg_dst, mem_to_reg});
    end
    tick();
    exp_count++;
    checks++;
    if (count !== exp_count || mem_read !== 1'b1) begin
      errors++; $display("FAIL add_retire: count %0d mem_read %b expected %0d 1", count, mem_read, exp_count);
    end
  endtask

  task automatic test_lw_waits();
    logic [7:0] rdy = 8'b01010100;
    logic [7:0] e_rd = 8'b01100111;
    logic [7:0] e_iord = 8'b01100000;
    logic [7:0] e_wb = 8'b10000000;
    int irw = 0;
    op = 6'b100011; funct = 6'd0;
    for (int i = 0; i < 8; i++) begin
      ready = rdy[i];
      #1;
      if (ir_write === 1'b1) irw++;
      checks++;
      if ({mem_read, iord, mem_to_reg, reg_write, mem_write} !== {e_rd[i], e_iord[i], e_wb[i], e_wb[i], 1'b0}) begin
        errors++;
        $display("FAIL lw_cycle%0d: got %b expected %b", i + 1, {mem_read, iord, mem_to_reg, reg_write, mem_write},
                 {e_rd[i], e_iord[i], e_wb[i], e_wb[i], 1'b0});
      end
      tick();
    end
    exp_count++;
    checks++;
    if (irw != 1) begin errors++; $display("FAIL lw_ir_write_pulses: got %0d expected 1", irw); end
    ready = 1'b1;
    #1;
    checks++;
    if (count !== exp_count || mem_read !== 1'b1 || ir_write !== 1'b1) begin
      errors++; $display("FAIL lw_retire: count %0d mem_read %b expected %0d 1", count, mem_read, exp_count);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [2] = '{6'b000101, 6'b000100};
    logic       ez  [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      op = ops[k]; ready = 1'b1;
      tick();
      tick();
      op = 6'b000101;  // ignored outside DECODE
      #1;
      checks++;
      if ({pc_write_cond, alu_op, pc_source, alu_src_a, zero_sel, pc_write} !== {1'b1, 3'b110, 2'b01, 2'b01, ez[k], 1'b0}) begin
        errors++;
        $display("FAIL branch%0d: got %b expected %b", k, {pc_write_cond, alu_op, pc_source, alu_src_a, zero_sel, pc_write},
                 {1'b1, 3'b110, 2'b01, 2'b01, ez[k], 1'b0});
      end
      tick();
      exp_count++;
      checks++;
      if (count !== exp_count || mem_read !== 1'b1) begin
        errors++; $display("FAIL branch%0d_retire: count %0d expected %0d", k, count, exp_count);
      end
    end
  endtask

  task automatic test_shift_imm();
    logic [5:0] ops [6] = '{6'd0, 6'd0, 6'b001101, 6'b001001, 6'b001111, 6'b001000};
    logic [5:0] fns [6] = '{6'd3, 6'd7, 6'd0, 6'd0, 6'd0, 6'd0};
    logic [1:0] ea  [6] = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] eb  [6] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [2:0] eop [6] = '{3'b010, 3'b010, 3'b001, 3'b111, 3'b100, 3'b000};
    logic       eim [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       edt [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      op = ops[k]; funct = fns[k]; ready = 1'b1;
      tick();
      tick();
      checks++;
      if ({alu_src_a, alu_src_b, alu_op, imm_ext_sel, reg_write} !== {ea[k], eb[k], eop[k], eim[k], 1'b0}) begin
        errors++;
        $display("FAIL exec%0d: got %b expected %b", k, {alu_src_a, alu_src_b, alu_op, imm_ext_sel, reg_write},
                 {ea[k], eb[k], eop[k], eim[k], 1'b0});
      end
      tick();
      checks++;
      if ({reg_write, reg_dst, mem_to_reg} !== {1'b1, edt[k], 1'b0}) begin
        errors++; $display("FAIL wb%0d: got %b expected %b", k, {reg_write, reg_dst, mem_to_reg}, {1'b1, edt[k], 1'b0});
      end
      tick();
      exp_count++;
    end
    checks++;
    if (count !== exp_count) begin errors++; $display("FAIL shift_imm_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_illegal();
    op = 6'b111111; ready = 1'b1;
    tick();
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", illegal); end
    tick();
    checks++;
    if ({illegal, mem_read} !== 2'b01 || count !== exp_count) begin
      errors++; $display("FAIL illegal_return: illegal %b mem_read %b count %0d expected 0 1 %0d", illegal, mem_read, count, exp_count);
    end
  endtask

  task automatic test_jump();
    op = 6'b000010; ready = 1'b1;
    tick(); tick();
    checks++;
    if ({pc_write, pc_source, pc_write_cond, reg_write} !== 5'b11000) begin
      errors++; $display("FAIL jump: got %b expected 11000", {pc_write, pc_source, pc_write_cond, reg_write});
    end
    tick();
    exp_count++;
    checks++;
    if (count !== exp_count) begin errors++; $display("FAIL jump_count: got %0d expected %0d", count, exp_count); end
  endtask

  task automatic test_back_to_back();
    op = 6'b101011; ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({mem_write, mem_read, iord} !== 3'b101) begin
      errors++; $display("FAIL sw_memwr: got %b expected 101", {mem_write, mem_read, iord});
    end
    tick();
    exp_count++;
    checks++;
    if (count !== exp_count || mem_read !== 1'b1) begin
      errors++; $display("FAIL sw_retire: count %0d expected %0d", count, exp_count);
    end
    tick(); tick();
    ready = 1'b0;
    tick(); tick();
    checks++;
    if ({mem_write, mem_read} !== 2'b10) begin
      errors++; $display("FAIL sw_hold: got %b expected 10", {mem_write, mem_read});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_write, reg_write, pc_write, mem_read} !== 4'b0 || count !== 32'd0) begin
      errors++; $display("FAIL async_abort: got %b count %0d expected 0000 0", {mem_write, reg_write, pc_write, mem_read}, count);
    end
    tick();
    rst = 1'b0; ready = 1'b1;
    tick();
    checks++;
    if ({mem_read, mem_write, iord} !== 3'b100 || count !== 32'd0) begin
      errors++; $display("FAIL restart: got %b count %0d expected 100 0", {mem_read, mem_write, iord}, count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_waits();
    test_branch();
    test_shift_imm();
    test_illegal();
    test_jump();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
